// File: rtl/branch_predictor_gen.sv
// Branch predictor: direct-mapped tagged BTB with control-transfer type,
// 2-bit saturating counter table (bimodal or gshare) and a return address stack.
// Lookup is combinational on fetchPc; all state updates come from resolved execute.
module branch_predictor_gen #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned HIST_BITS   = 8,
  parameter int unsigned USE_GSHARE  = 1,
  parameter int unsigned RAS_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [XLEN-1:0]              fetchPc,
  output logic                         fetchHit,
  output logic [XLEN-1:0]              fetchTarget,
  input  logic                         exValid,
  input  logic [XLEN-1:0]              exPc,
  input  logic                         exBranch,
  input  logic                         exJump,
  input  logic                         exCall,
  input  logic                         exRet,
  input  logic                         exTaken,
  input  logic [XLEN-1:0]              exTarget,
  output logic [$clog2(RAS_DEPTH):0]   rasCount
);

  localparam int unsigned BtbIdxW = $clog2(BTB_ENTRIES);
  localparam int unsigned TagW    = XLEN - BtbIdxW - 2;
  localparam int unsigned PhtIdxW = $clog2(PHT_ENTRIES);
  localparam int unsigned RasPtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW    = RasPtrW + 1;

  typedef enum logic [1:0] {
    TypeBranch = 2'b00,
    TypeJump   = 2'b01,
    TypeCall   = 2'b10,
    TypeRet    = 2'b11
  } cfType_t;

  typedef struct packed {
    logic            valid;
    logic [TagW-1:0] tag;
    logic [XLEN-1:0] target;
    cfType_t         kind;
  } btbEntry_t;

  btbEntry_t             btbMem [BTB_ENTRIES];
  logic [1:0]            phtMem [PHT_ENTRIES];
  logic [XLEN-1:0]       rasMem [RAS_DEPTH];
  logic [HIST_BITS-1:0]  ghr;
  logic [RasPtrW-1:0]    rasPtr;

  logic [BtbIdxW-1:0]    fetchBtbIdx, exBtbIdx;
  logic [TagW-1:0]       fetchTag, exTag;
  logic [PhtIdxW-1:0]    fetchPhtIdx, exPhtIdx;
  logic [XLEN-1:0]       rasTop;
  btbEntry_t             fetchEntry;
  logic                  unusedBits;

  logic                  exNonBranch, btbWrite, phtWrite;
  cfType_t               exKind;
  logic [1:0]            phtOld, phtNew;
  logic [HIST_BITS-1:0]  ghrNext;
  logic                  rasWrite;
  logic [RasPtrW-1:0]    rasWriteIdx, rasPtrNext;
  logic [CntW-1:0]       rasCountNext;

  // PHT index: word-aligned PC bits, optionally hashed with global history
  function automatic logic [PhtIdxW-1:0] phtIndex(input logic [XLEN-1:0] pc,
                                                  input logic [HIST_BITS-1:0] hist);
    logic [PhtIdxW-1:0] idx;
    idx = pc[PhtIdxW+1:2];
    if (USE_GSHARE != 0) idx = idx ^ PhtIdxW'(hist);
    return idx;
  endfunction

  assign fetchBtbIdx = fetchPc[BtbIdxW+1:2];
  assign fetchTag    = fetchPc[XLEN-1:BtbIdxW+2];
  assign exBtbIdx    = exPc[BtbIdxW+1:2];
  assign exTag       = exPc[XLEN-1:BtbIdxW+2];
  assign fetchPhtIdx = phtIndex(fetchPc, ghr);
  assign exPhtIdx    = phtIndex(exPc, ghr);
  assign fetchEntry  = btbMem[fetchBtbIdx];
  assign rasTop      = rasMem[RasPtrW'(rasPtr - RasPtrW'(1))];
  assign unusedBits  = ^{fetchPc[1:0], exPc[1:0]};

  // Zero-latency lookup on pre-update state
  always_comb begin
    fetchHit    = 1'b0;
    fetchTarget = '0;
    if (fetchEntry.valid && fetchEntry.tag == fetchTag) begin
      fetchHit    = (fetchEntry.kind != TypeBranch) || phtMem[fetchPhtIdx][1];
      fetchTarget = (fetchEntry.kind == TypeRet && rasCount != '0) ? rasTop
                                                                    : fetchEntry.target;
    end
  end

  // Resolved-instruction update decode: BTB write, counter step, history shift
  always_comb begin
    exNonBranch = exJump | exCall | exRet;
    btbWrite    = exValid & (exNonBranch | (exBranch & exTaken));
    phtWrite    = exValid & exBranch;
    if (exRet)       exKind = TypeRet;
    else if (exCall) exKind = TypeCall;
    else if (exJump) exKind = TypeJump;
    else             exKind = TypeBranch;
    phtOld = phtMem[exPhtIdx];
    if (exTaken) phtNew = (phtOld == 2'b11) ? 2'b11 : 2'(phtOld + 2'd1);
    else         phtNew = (phtOld == 2'b00) ? 2'b00 : 2'(phtOld - 2'd1);
    ghrNext = HIST_BITS'({ghr, exTaken});
  end

  // RAS next state: coroutine is pop-then-push, full push overwrites oldest
  always_comb begin
    rasWrite     = 1'b0;
    rasWriteIdx  = rasPtr;
    rasPtrNext   = rasPtr;
    rasCountNext = rasCount;
    if (exValid) begin
      if (exCall && exRet) begin
        rasWrite = 1'b1;
        if (rasCount != '0) begin
          rasWriteIdx = RasPtrW'(rasPtr - RasPtrW'(1));
        end else begin
          rasPtrNext   = RasPtrW'(rasPtr + RasPtrW'(1));
          rasCountNext = CntW'(1);
        end
      end else if (exCall) begin
        rasWrite     = 1'b1;
        rasPtrNext   = RasPtrW'(rasPtr + RasPtrW'(1));
        rasCountNext = (rasCount == CntW'(RAS_DEPTH)) ? rasCount : CntW'(rasCount + CntW'(1));
      end else if (exRet && rasCount != '0) begin
        rasPtrNext   = RasPtrW'(rasPtr - RasPtrW'(1));
        rasCountNext = CntW'(rasCount - CntW'(1));
      end
    end
  end

  // Predictor state registers; reset wins over any same-cycle update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) btbMem[i].valid <= 1'b0;
      for (int i = 0; i < int'(PHT_ENTRIES); i++) phtMem[i] <= 2'b01;
      ghr      <= '0;
      rasPtr   <= '0;
      rasCount <= '0;
    end else begin
      if (btbWrite) btbMem[exBtbIdx] <= '{valid: 1'b1, tag: exTag, target: exTarget, kind: exKind};
      if (phtWrite) begin
        phtMem[exPhtIdx] <= phtNew;
        ghr              <= ghrNext;
      end
      rasPtr   <= rasPtrNext;
      rasCount <= rasCountNext;
    end
  end

  // RAS storage has no reset; occupancy alone qualifies its contents
  always_ff @(posedge clk) begin
    if (!rst && rasWrite) rasMem[rasWriteIdx] <= XLEN'(exPc + XLEN'(4));
  end

endmodule

// File: tb/tb_branch_predictor_gen.sv
// Directed bench: a bimodal instance and a gshare (2-bit history) instance share stimulus.
module tb_branch_predictor_gen;

  logic        clk, rst;
  logic [31:0] fetchPc, exPc, exTarget;
  logic        exValid, exBranch, exJump, exCall, exRet, exTaken;
  logic        hitB, hitG;
  logic [31:0] tgtB, tgtG;
  logic [2:0]  cntB, cntG;
  int          checks = 0;
  int          failures = 0;

  branch_predictor_gen #(.USE_GSHARE(0)) dutB (
    .clk(clk), .rst(rst), .fetchPc(fetchPc), .fetchHit(hitB), .fetchTarget(tgtB),
    .exValid(exValid), .exPc(exPc), .exBranch(exBranch), .exJump(exJump), .exCall(exCall),
    .exRet(exRet), .exTaken(exTaken), .exTarget(exTarget), .rasCount(cntB));

  branch_predictor_gen #(.USE_GSHARE(1), .HIST_BITS(2)) dutG (
    .clk(clk), .rst(rst), .fetchPc(fetchPc), .fetchHit(hitG), .fetchTarget(tgtG),
    .exValid(exValid), .exPc(exPc), .exBranch(exBranch), .exJump(exJump), .exCall(exCall),
    .exRet(exRet), .exTaken(exTaken), .exTarget(exTarget), .rasCount(cntG));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setEx(input logic [31:0] pc, input logic br, input logic jmp,
                       input logic call, input logic ret, input logic tk, input logic [31:0] tgt);
    exValid = 1'b1; exPc = pc; exBranch = br; exJump = jmp;
    exCall = call; exRet = ret; exTaken = tk; exTarget = tgt;
  endtask

  task automatic clrEx();
    exValid = 1'b0; exBranch = 1'b0; exJump = 1'b0; exCall = 1'b0; exRet = 1'b0; exTaken = 1'b0;
  endtask

  // One resolved instruction, applied on the next rising edge
  task automatic exec(input logic [31:0] pc, input logic br, input logic jmp,
                      input logic call, input logic ret, input logic tk, input logic [31:0] tgt);
    setEx(pc, br, jmp, call, ret, tk, tgt);
    tick();
    clrEx();
  endtask

  task automatic look(input logic [31:0] pc);
    fetchPc = pc;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetchPc = '0; exPc = '0; exTarget = '0;
    clrEx();
    tick();
    doReset();

    // Reset state
    look(32'h100);
    chk("rst_hit", 32'(hitB), 32'd0);
    chk("rst_tgt", tgtB, 32'h0);
    chk("rst_cnt", 32'(cntB), 32'd0);

    // Bimodal branch training 01->10->11, then back down
    exec(32'h100, 1, 0, 0, 0, 1, 32'h140);
    look(32'h100);
    chk("br_t1_hit", 32'(hitB), 32'd1);
    exec(32'h100, 1, 0, 0, 0, 1, 32'h140);
    look(32'h100);
    chk("br_t2_hit", 32'(hitB), 32'd1);
    chk("br_t2_tgt", tgtB, 32'h140);
    exec(32'h100, 1, 0, 0, 0, 0, 32'h140);
    look(32'h100);
    chk("br_n1_hit", 32'(hitB), 32'd1);
    exec(32'h100, 1, 0, 0, 0, 0, 32'h140);
    look(32'h100);
    chk("br_n2_hit", 32'(hitB), 32'd0);

    // Call then return
    exec(32'h200, 0, 1'b0, 1, 0, 0, 32'h800);
    look(32'h200);
    chk("call_hit", 32'(hitB), 32'd1);
    chk("call_tgt", tgtB, 32'h800);
    chk("call_cnt", 32'(cntB), 32'd1);
    exec(32'h810, 0, 0, 0, 1, 0, 32'h204);
    chk("ret_cnt", 32'(cntB), 32'd0);
    look(32'h810);
    chk("ret_empty_tgt", tgtB, 32'h204);
    exec(32'h200, 0, 0, 1, 0, 0, 32'h800);
    chk("call2_cnt", 32'(cntB), 32'd1);
    look(32'h810);
    chk("ret_ras_hit", 32'(hitB), 32'd1);
    chk("ret_ras_tgt", tgtB, 32'h204);

    // Ret entry at 0x904 used to observe the RAS top
    exec(32'h904, 0, 0, 0, 1, 0, 32'hABC);
    chk("drain_cnt", 32'(cntB), 32'd0);
    for (int i = 1; i <= 5; i++) exec(32'(i * 16), 0, 0, 1, 0, 0, 32'h1000);
    chk("full_cnt", 32'(cntB), 32'd4);
    for (int i = 0; i < 4; i++) begin
      look(32'h904);
      chk($sformatf("pop%0d_top", i), tgtB, 32'(32'h54 - 32'(i) * 32'h10));
      exec(32'h904, 0, 0, 0, 1, 0, 32'hABC);
      chk($sformatf("pop%0d_cnt", i), 32'(cntB), 32'(3 - i));
    end
    look(32'h904);
    chk("empty_tgt", tgtB, 32'hABC);
    exec(32'h904, 0, 0, 0, 1, 0, 32'hABC);
    chk("pop_empty_cnt", 32'(cntB), 32'd0);

    // Coroutine with non-empty stack: occupancy unchanged, top replaced
    exec(32'h10, 0, 0, 1, 0, 0, 32'h1000);
    exec(32'h60, 0, 0, 1, 1, 0, 32'h1000);
    chk("corout_cnt", 32'(cntB), 32'd1);
    look(32'h60);
    chk("corout_top", tgtB, 32'h64);

    // Same-cycle lookup and update of 0x300
    fetchPc = 32'h300;
    setEx(32'h300, 0, 1, 0, 0, 0, 32'h900);
    #1;
    chk("same_cyc_hit", 32'(hitB), 32'd0);
    tick();
    clrEx();
    look(32'h300);
    chk("next_cyc_hit", 32'(hitB), 32'd1);
    chk("next_cyc_tgt", tgtB, 32'h900);

    // Gshare with 2-bit history learns alternating T/N at 0x400
    doReset();
    for (int i = 0; i < 8; i++) begin
      look(32'h400);
      if (i >= 3) begin
        chk($sformatf("gs%0d_hit", i), 32'(hitG), 32'((i % 2) == 0));
        if ((i % 2) == 0) chk($sformatf("gs%0d_tgt", i), tgtG, 32'h440);
      end
      exec(32'h400, 1, 0, 0, 0, 1'((i % 2) == 0), 32'h440);
    end

    // Reset during an update discards it and clears everything
    exec(32'h500, 0, 1, 0, 0, 0, 32'h600);
    look(32'h500);
    chk("pre_rst_hit", 32'(hitB), 32'd1);
    rst = 1'b1;
    setEx(32'h700, 0, 0, 1, 0, 0, 32'h780);
    tick();
    clrEx();
    rst = 1'b0;
    look(32'h500);
    chk("rst_clr_hit", 32'(hitB), 32'd0);
    chk("rst_clr_tgt", tgtB, 32'h0);
    look(32'h700);
    chk("rst_upd_hit", 32'(hitB), 32'd0);
    chk("rst_upd_cntB", 32'(cntB), 32'd0);
    chk("rst_upd_cntG", 32'(cntG), 32'd0);
    look(32'h400);
    chk("rst_gs_hit", 32'(hitG), 32'd0);
    // Counters back at weakly not-taken: one taken makes it predict taken
    exec(32'h400, 1, 0, 0, 0, 1, 32'h440);
    look(32'h400);
    chk("rst_pht_hit", 32'(hitB), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
